// File: rtl/pipelined_adder_acc_if.sv
// pipelined_adder_acc_if
//   Handshake and data bundle for pipelined_adder_acc.
//   master : the block driving operands (clk_en, in_valid, mode, a, b, cin,
//            acc_clr) and observing in_ready and the result
//            (sum, carry, overflow, out_valid).
//   slave  : the adder itself.
interface pipelined_adder_acc_if #(
  parameter int WIDTH = 8
);
  logic             clk_en;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             acc_clr;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             out_valid;

  modport master (
    output clk_en, in_valid, mode, a, b, cin, acc_clr,
    input  in_ready, sum, carry, overflow, out_valid
  );

  modport slave (
    input  clk_en, in_valid, mode, a, b, cin, acc_clr,
    output in_ready, sum, carry, overflow, out_valid
  );
endinterface

// File: rtl/pipelined_adder_acc.sv
// pipelined_adder_acc
//   WIDTH-bit adder split into STAGES carry-pipelined chunks of CH bits.
//   Stage 0 registers the operands; each following stage adds one chunk and
//   forwards the carry, the finished low bits and the untouched high bits.
//   The last stage drives the registered result. Mode=1 adds the internal
//   accumulator instead of b; while such an op is in flight in_ready is low.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : pipelined_adder_acc_if.slave (handshake, operands, result)
module pipelined_adder_acc #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_adder_acc_if.slave   bus
);

  localparam int CH   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((WIDTH < 2) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
    $error("pipelined_adder_acc: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Pipeline slot k holds an op whose chunks 0..k-1 are already summed;
  // the summed bits overwrite the a field in place.
  logic [WIDTH-1:0] st_a_r [STAGES];
  logic [WIDTH-1:0] st_b_r [STAGES];
  logic             st_c_r [STAGES];
  logic             st_m_r [STAGES];
  logic             st_v_r [STAGES];

  logic [CH:0]      csum_s [STAGES];
  logic [WIDTH-1:0] nx_a_s [STAGES];

  logic             acc_busy_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             overflow_r;
  logic             out_valid_r;

  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] op2_s;
  logic             msb_cin_s;
  logic             exit_acc_s;

  // Chunk-wide add with carry-in; carry-out lands in the top bit.
  function automatic logic [CH:0] chunk_add(input logic [CH-1:0] x,
                                            input logic [CH-1:0] y,
                                            input logic          c);
    return {1'b0, x} + {1'b0, y} + {{CH{1'b0}}, c};
  endfunction

  assign in_ready_s = bus.clk_en & ~acc_busy_r;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign exit_acc_s = st_v_r[LAST] & st_m_r[LAST];

  // Second operand: b, or the accumulator (zero when cleared in the same cycle).
  always_comb begin
    op2_s = bus.b;
    if (bus.mode) begin
      if (bus.acc_clr) begin
        op2_s = {WIDTH{1'b0}};
      end else begin
        op2_s = acc_r;
      end
    end else begin
      op2_s = bus.b;
    end
  end

  // Per-slot chunk addition; slot k works on chunk k.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      csum_s[k] = chunk_add(st_a_r[k][k*CH +: CH], st_b_r[k][k*CH +: CH], st_c_r[k]);
      nx_a_s[k] = st_a_r[k];
      nx_a_s[k][k*CH +: CH] = csum_s[k][CH-1:0];
    end
  end

  // The carry into the MSB is recovered from the MSB's operand and sum bits.
  assign msb_cin_s = st_a_r[LAST][WIDTH-1] ^ st_b_r[LAST][WIDTH-1] ^ nx_a_s[LAST][WIDTH-1];

  // Pipeline slots: slot 0 captures operands, later slots take the previous slot's partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_a_r[k] <= {WIDTH{1'b0}};
        st_b_r[k] <= {WIDTH{1'b0}};
        st_c_r[k] <= 1'b0;
        st_m_r[k] <= 1'b0;
        st_v_r[k] <= 1'b0;
      end
    end else if (bus.clk_en) begin
      st_a_r[0] <= bus.a;
      st_b_r[0] <= op2_s;
      st_c_r[0] <= bus.cin;
      st_m_r[0] <= bus.mode;
      st_v_r[0] <= accept_s;
      for (int k = 1; k < STAGES; k++) begin
        st_a_r[k] <= nx_a_s[k-1];
        st_b_r[k] <= st_b_r[k-1];
        st_c_r[k] <= csum_s[k-1][CH];
        st_m_r[k] <= st_m_r[k-1];
        st_v_r[k] <= st_v_r[k-1];
      end
    end
  end

  // Output register: result updates only for valid slots, so sum holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (bus.clk_en) begin
      out_valid_r <= st_v_r[LAST];
      if (st_v_r[LAST]) begin
        sum_r      <= nx_a_s[LAST];
        carry_r    <= csum_s[LAST][CH];
        overflow_r <= msb_cin_s ^ csum_s[LAST][CH];
      end
    end
  end

  // Accumulator: clear wins over the update from an exiting accumulate op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (bus.clk_en) begin
      if (bus.acc_clr) begin
        acc_r <= {WIDTH{1'b0}};
      end else if (exit_acc_s) begin
        acc_r <= nx_a_s[LAST];
      end
    end
  end

  // Interlock: at most one accumulate op in flight, since it reads acc at entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_busy_r <= 1'b0;
    end else if (bus.clk_en) begin
      if (accept_s && bus.mode) begin
        acc_busy_r <= 1'b1;
      end else if (exit_acc_s) begin
        acc_busy_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.sum       = sum_r;
  assign bus.carry     = carry_r;
  assign bus.overflow  = overflow_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_pipelined_adder_acc.sv
// tb_pipelined_adder_acc
//   Self-checking bench for pipelined_adder_acc (WIDTH=8, STAGES=2).
//   A reference model tracks in-flight ops as a queue with countdowns and
//   computes results with plain integer arithmetic; every cycle in_ready and
//   the outputs are compared against it. Directed tables and sequences cover
//   the listed corner cases, followed by randomized traffic.
module tb_pipelined_adder_acc;
  localparam int W = 8;
  localparam int S = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_acc_if #(.WIDTH(W)) bus ();
  pipelined_adder_acc #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         m;
    int           rem;
  } fl_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  fl_t          q[$];
  res_t         out_log[$];
  logic         rdy_log[$];
  logic [W-1:0] m_acc;
  logic [W-1:0] e_sum;
  logic         e_c, e_v, e_ov;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    foreach (q[i]) if (q[i].m) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic v, input logic m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input logic clr,
                       input logic en);
    bus.in_valid = v;
    bus.mode     = m;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.acc_clr  = clr;
    bus.clk_en   = en;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_sum"},       32'(bus.sum),       32'(e_sum));
    chk({tag, "_carry"},     32'(bus.carry),     32'(e_c));
    chk({tag, "_overflow"},  32'(bus.overflow),  32'(e_v));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(e_ov));
  endtask

  // One clock cycle: check in_ready, pass the edge, advance the model, check outputs.
  task automatic tick();
    logic         exp_rdy, c_acc, c_m, c_clr, c_en;
    logic [W-1:0] op2;
    logic [W:0]   full;
    fl_t          nf;
    res_t         r;
    #1;
    exp_rdy = bus.clk_en & ~model_busy();
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    rdy_log.push_back(bus.in_ready);
    c_en  = bus.clk_en;
    c_acc = bus.in_valid & exp_rdy;
    c_m   = bus.mode;
    c_clr = bus.acc_clr;
    op2   = c_m ? (c_clr ? {W{1'b0}} : m_acc) : bus.b;
    full  = {1'b0, bus.a} + {1'b0, op2} + {{W{1'b0}}, bus.cin};
    nf.s   = full[W-1:0];
    nf.c   = full[W];
    nf.v   = (bus.a[W-1] == op2[W-1]) && (full[W-1] != bus.a[W-1]);
    nf.m   = c_m;
    nf.rem = S;
    @(posedge clk);
    if (c_en) begin
      e_ov = 1'b0;
      foreach (q[i]) q[i].rem = q[i].rem - 1;
      if (q.size() > 0 && q[0].rem == 0) begin
        e_sum = q[0].s;
        e_c   = q[0].c;
        e_v   = q[0].v;
        e_ov  = 1'b1;
        if (q[0].m) m_acc = q[0].s;
        void'(q.pop_front());
      end
      if (c_clr) m_acc = {W{1'b0}};
      if (c_acc) q.push_back(nf);
    end
    #1;
    check_outputs("cyc");
    if (bus.out_valid) begin
      r.s = bus.sum;
      r.c = bus.carry;
      r.v = bus.overflow;
      out_log.push_back(r);
    end
  endtask

  // Asynchronous reset pulse: outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    m_acc = '0;
    e_sum = '0;
    e_c   = 1'b0;
    e_v   = 1'b0;
    e_ov  = 1'b0;
    #1;
    check_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tv[5];

  initial begin
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #2;
    do_reset();

    // Mode-0 table, applied back to back.
    tv[0] = '{a: 8'h3C, b: 8'h5A, cin: 1'b0, s: 8'h96, c: 1'b0, v: 1'b1};
    tv[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1, v: 1'b0};
    tv[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, c: 1'b0, v: 1'b1};
    tv[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1, v: 1'b1};
    tv[4] = '{a: 8'h0F, b: 8'hF0, cin: 1'b1, s: 8'h00, c: 1'b1, v: 1'b0};
    out_log.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, tv[i].a, tv[i].b, tv[i].cin, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    chk("tab_count", 32'(out_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < out_log.size()) begin
        chk("tab_sum",   32'(out_log[i].s), 32'(tv[i].s));
        chk("tab_carry", 32'(out_log[i].c), 32'(tv[i].c));
        chk("tab_ovf",   32'(out_log[i].v), 32'(tv[i].v));
      end
    end

    // Accumulate: clear, then 3 ops of +0x10 held with in_valid.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    rdy_log.delete();
    out_log.delete();
    drive(1'b1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (9) tick();
    for (int i = 0; i < 9; i++) begin
      chk("acc_ready_pattern", 32'(rdy_log[i]), (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    chk("acc_count", 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("acc_sum", 32'(out_log[i].s), 32'(16 * (i + 1)));
      chk("acc_value", 32'(out_log[3].s), 32'h30);
    end

    // Clock-enable hold for two cycles after an accept.
    do_reset();
    drive(1'b1, 1'b0, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h11, 8'h11, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    chk("hold_not_yet", 32'(bus.out_valid), 32'd0);
    tick();
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_sum", 32'(bus.sum), 32'h96);
    tick();
    chk("hold_one_pulse", 32'(bus.out_valid), 32'd0);
    chk("hold_sum_kept", 32'(bus.sum), 32'h96);

    // Reset with ops in flight: nothing may emerge afterwards.
    drive(1'b1, 1'b0, 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    do_reset();
    out_log.delete();
    repeat (5) tick();
    chk("rst_no_valid", 32'(out_log.size()), 32'd0);

    // Clear on the same edge an accumulate result exits.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1, 8'h22, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    chk("clr_exit_valid", 32'(bus.out_valid), 32'd1);
    chk("clr_exit_sum", 32'(bus.sum), 32'h22);
    drive(1'b1, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    chk("clr_exit_next", 32'(bus.sum), 32'h05);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
            8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) != 0));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
